dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Load/store access unit between the CPU MEM stage and the 16384×32 byte-writable data SRAM. It converts RV32I byte addresses, funct3 size codes and store data into SRAM word address, active-low byte write strobes and lane-shifted write data. It also extracts and sign- or zero-extends load data. Accesses that cross a word boundary are split into two SRAM accesses, and the unit stalls the MEM stage through a valid/ready handshake.

## Interface
- ADDR_W, 14, SRAM word-address width; word index = req_addr[ADDR_W+1:2].
- DATA_W, 32, data width (fixed at 32; four byte lanes).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM-stage request present.
- req_ready  out  1  unit can accept; transfer when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  32  extended load data (0 for stores and errors); valid only with rsp_valid.
- rsp_err  out  1  illegal funct3; valid only with rsp_valid.
- sram_cs  out  1  SRAM chip select.
- sram_oe  out  1  SRAM output enable.
- sram_web  out  4  active-low byte write enables; bit i = lane i (bits 8i+7:8i).
- sram_a  out  ADDR_W  SRAM word address.
- sram_di  out  32  SRAM write data.
- sram_do  in  32  SRAM read data; holds the word addressed at the previous cs edge.

## Operation
- **Request latch.** The request is registered at acceptance. off = req_addr[1:0]; size mask M = 0x1 (byte), 0x3 (half), 0xF (word); lane mask L = M << off (8 bits).
- **Split rule.** Split iff L[7:4] != 0: a half at off=3, or a word at off!=0. Beat 1 addresses word W; beat 2 addresses W+1 mod 2^ADDR_W (16383 wraps to 0).
- **Store beats.**
  - Beat 1: sram_web = ~L[3:0], sram_di = req_wdata << 8·off.
  - Beat 2: sram_web = ~L[7:4], sram_di = req_wdata >> 8·(4−off).
- **Load beats.** sram_web = 4'hF on both beats.
- **Load merge.**
  - Unsplit: raw = sram_do >> 8·off.
  - Split: raw = (beat-1 data >> 8·off) | (beat-2 data << 8·(4−off)).
  - Extraction: LB/LH sign-extend raw[7:0]/raw[15:0]; LBU/LHU zero-extend; LW uses raw unchanged.
- **Illegal funct3.** Loads with 011, 110 or 111; stores with funct3 > 010. No SRAM access; go directly to RSP with rsp_err=1 and rsp_rdata=0.

State machine:
- **IDLE**
  - req_ready=1, sram_cs=0, sram_oe=0.
  - On accept: legal → S1; illegal → RSP.
- **S1**
  - sram_cs=1; beat-1 address, web and di driven from registered state.
  - Next: S2 if split, else RSP.
- **S2**
  - sram_cs=1, sram_oe=1; beat-2 address, web and di driven.
  - Beat-1 sram_do captured into a holding register at the end of S2.
  - Next: RSP.
- **RSP**
  - sram_cs=0, sram_oe=1 (data read only for loads); rsp_valid=1; rsp_rdata/rsp_err are the merged or error result.
  - Next: IDLE.
- req_ready=0 in S1, S2 and RSP. A request presented then is held by the MEM stage; no queueing.
- Outside S1/S2: sram_web=4'hF, sram_di=0, sram_a holds its last value.

## Timing
- **Reset values** (during and after rst):
  - state IDLE; req_ready=0 while rst=1, then 1 in IDLE.
  - sram_cs=0, sram_oe=0, sram_web=4'hF, sram_a=0, sram_di=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0; holding register 0.
- **Latency** (accept at edge T):
  - Unsplit: S1 in cycle T+1, rsp_valid in cycle T+2.
  - Split: S1 in T+1, S2 in T+2, rsp_valid in T+3.
  - Illegal: rsp_valid in T+1.
- **Throughput.** Next accept no earlier than the edge ending RSP: one request per 3 cycles unsplit, per 4 split, per 2 illegal.
- **SRAM contract.** The SRAM samples cs/a/web/di at the edge ending S1 or S2. Read data appears on sram_do in the following cycle.
- **Reset mid-operation.** rst in any state returns to IDLE at that edge, with sram_cs=0 from the next cycle and no rsp_valid. A beat already sampled by the SRAM stays written; a split store may be left half-written.
- **Simultaneous events.** req_valid together with rst is ignored.

## Test plan
- **Aligned SW.** SW addr 0x10, data 0xDEADBEEF accepted at T → cycle T+1: cs=1, a=4, web=0000, di=0xDEADBEEF; T+2: rsp_valid=1, rsp_err=0, rdata=0.
- **LB/LBU extension.** Word 4 = 0x80FF1234. LB addr 0x13 → rdata 0xFFFFFF80 at T+2; LBU addr 0x13 → 0x00000080; LH addr 0x12 → 0xFFFF80FF.
- **Split LW.** Word 4 = 0x80FF1234, word 5 = 0x5566AABB. LW addr 0x12 → a=4 in T+1, a=5 in T+2, web=1111 both beats; rdata 0xAABB80FF with rsp_valid at T+3.
- **Split SH.** SH addr 0x7, data 0x0000CAFE → beat 1: a=1, web=0111, di=0xFE000000; beat 2: a=2, web=1110, di=0x000000CA. Readback LHU 0x7 → 0x0000CAFE.
- **Address wrap.** LW addr 0xFFFE → a=16383 then a=0; merged result takes bytes 2–3 of word 16383 and bytes 0–1 of word 0.
- **Error and reset.** Load funct3 011 → no cs pulse, rsp_valid and rsp_err=1 at T+1, rdata=0. rst asserted during S2 of a split SW → cs=0 next cycle, no rsp_valid, req_ready=1 after rst drops.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//   Load/store access unit between the CPU MEM stage and a byte-writable
//   (2**ADDR_W) x 32 data SRAM. It accepts one RV32I load/store at a time over a
//   valid/ready handshake and turns it into one or two SRAM beats. Two beats are
//   needed when the access crosses a word boundary. Load data is merged,
//   lane-aligned and then sign- or zero-extended.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     req_*             MEM-stage request (valid/ready, we, funct3, byte addr, wdata)
//     rsp_*             one-cycle completion pulse with load data / error flag
//     sram_cs/oe/web    SRAM chip select, output enable, active-low byte writes
//     sram_a/di/do      SRAM word address, write data, read data (1-cycle latency)
//
//   Sequence: IDLE -> S1 [-> S2] -> RSP -> IDLE. Illegal funct3 goes straight
//   from IDLE to RSP with no SRAM access.

// Per-lane store steering. For byte lane LANE, this module works out which
// store-data byte lands here on beat 1 (word W) and on beat 2 (word W+1).
// It also reports whether the access touches this lane on each beat.
module dmem_access_unit_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  off,        // byte offset within the word
    input  logic [3:0]  size_mask,  // 0x1 byte, 0x3 half, 0xF word
    input  logic [31:0] wdata,      // right-justified store data
    output logic        en_lo,      // lane written on beat 1
    output logic        en_hi,      // lane written on beat 2
    output logic [7:0]  byte_lo,    // lane byte of wdata << 8*off
    output logic [7:0]  byte_hi     // lane byte of wdata >> 8*(4-off)
);
    // Index of the source byte feeding this lane. Bit 2 set means the index
    // fell outside 0..3, so no byte reaches this lane on that beat.
    logic [2:0] k_lo;
    logic [2:0] k_hi;

    assign k_lo = 3'(LANE) - {1'b0, off};
    assign k_hi = 3'(LANE) + 3'd4 - {1'b0, off};

    assign en_lo = ~k_lo[2] & size_mask[k_lo[1:0]];
    assign en_hi = ~k_hi[2] & size_mask[k_hi[1:0]];

    // Data lanes follow the plain shifts regardless of size, so bytes of wdata
    // above the access size still appear on the bus. Strobes mask them off.
    assign byte_lo = k_lo[2] ? 8'h00 : 8'(wdata >> {k_lo[1:0], 3'b000});
    assign byte_hi = k_hi[2] ? 8'h00 : 8'(wdata >> {k_hi[1:0], 3'b000});
endmodule

module dmem_access_unit #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic [3:0]        sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
);
    localparam int NUM_LANES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t state;

    // Request state latched at acceptance.
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              split_q;
    logic [3:0]        web_hi_q;   // beat-2 strobes, precomputed at accept
    logic [DATA_W-1:0] di_hi_q;    // beat-2 write data, precomputed at accept
    logic [DATA_W-1:0] hold_q;     // beat-1 read data for split loads

    // ---------------------------------------------------------------
    // Request decode (works on the live request; used at the accept edge)
    // ---------------------------------------------------------------
    logic [3:0] size_mask;
    logic       legal;

    always_comb begin
        size_mask = 4'hF;
        case (req_funct3[1:0])
            2'b00:   size_mask = 4'h1;
            2'b01:   size_mask = 4'h3;
            default: size_mask = 4'hF;
        endcase
    end

    always_comb begin
        legal = 1'b1;
        if (req_we)
            legal = (req_funct3 <= 3'b010);
        else
            legal = !(req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
    end

    logic [NUM_LANES-1:0]      en_lo;
    logic [NUM_LANES-1:0]      en_hi;
    logic [NUM_LANES-1:0][7:0] byte_lo;
    logic [NUM_LANES-1:0][7:0] byte_hi;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dmem_access_unit_lane #(.LANE(i)) u_lane (
            .off       (req_addr[1:0]),
            .size_mask (size_mask),
            .wdata     (req_wdata),
            .en_lo     (en_lo[i]),
            .en_hi     (en_hi[i]),
            .byte_lo   (byte_lo[i]),
            .byte_hi   (byte_hi[i])
        );
    end

    // Loads never write; their beats keep all strobes high and the data bus quiet.
    logic [3:0]        web_lo;
    logic [3:0]        web_hi;
    logic [DATA_W-1:0] di_lo;
    logic [DATA_W-1:0] di_hi;
    logic              split;

    assign web_lo = req_we ? ~en_lo : 4'hF;
    assign web_hi = req_we ? ~en_hi : 4'hF;
    assign di_lo  = req_we ? byte_lo : '0;
    assign di_hi  = req_we ? byte_hi : '0;
    assign split  = |en_hi;

    assign req_ready = (state == IDLE) && !rst;

    // ---------------------------------------------------------------
    // Sequencer. All SRAM-side and response outputs are registered here.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sram_cs   <= 1'b0;
            sram_oe   <= 1'b0;
            sram_web  <= 4'hF;
            sram_a    <= '0;
            sram_di   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            split_q   <= 1'b0;
            web_hi_q  <= 4'hF;
            di_hi_q   <= '0;
            hold_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q     <= req_we;
                        f3_q     <= req_funct3;
                        off_q    <= req_addr[1:0];
                        split_q  <= split;
                        web_hi_q <= web_hi;
                        di_hi_q  <= di_hi;
                        if (legal) begin
                            state    <= S1;
                            sram_cs  <= 1'b1;
                            sram_a   <= req_addr[ADDR_W+1:2];
                            sram_web <= web_lo;
                            sram_di  <= di_lo;
                        end else begin
                            state     <= RSP;
                            sram_oe   <= 1'b1;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                S1: begin
                    sram_oe <= 1'b1;
                    if (split_q) begin
                        // Next word, wrapping at the top of the array.
                        state    <= S2;
                        sram_a   <= sram_a + ADDR_W'(1);
                        sram_web <= web_hi_q;
                        sram_di  <= di_hi_q;
                    end else begin
                        state     <= RSP;
                        sram_cs   <= 1'b0;
                        sram_web  <= 4'hF;
                        sram_di   <= '0;
                        rsp_valid <= 1'b1;
                    end
                end
                S2: begin
                    // sram_do still shows the beat-1 word during S2.
                    hold_q    <= sram_do;
                    state     <= RSP;
                    sram_cs   <= 1'b0;
                    sram_web  <= 4'hF;
                    sram_di   <= '0;
                    rsp_valid <= 1'b1;
                end
                RSP: begin
                    state     <= IDLE;
                    sram_oe   <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Load merge. Read data only exists on sram_do during RSP, so this
    // path stays combinational off the registered request state.
    // ---------------------------------------------------------------
    logic [DATA_W-1:0]   lo_word;
    logic [DATA_W-1:0]   hi_word;
    logic [2*DATA_W-1:0] window;
    logic [DATA_W-1:0]   raw;
    logic [DATA_W-1:0]   ext;

    assign lo_word = split_q ? hold_q  : sram_do;
    assign hi_word = split_q ? sram_do : '0;
    assign window  = {hi_word, lo_word} >> {off_q, 3'b000};
    assign raw     = window[DATA_W-1:0];

    always_comb begin
        ext = raw;
        case (f3_q)
            3'b000:  ext = {{24{raw[7]}},  raw[7:0]};
            3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  ext = {24'h0, raw[7:0]};
            3'b101:  ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

    assign rsp_rdata = (rsp_valid && !rsp_err && !we_q) ? ext : '0;

    // Upper address bits are outside the SRAM. The top half of the merge
    // window is shifted-out residue.
    logic unused_ok;
    assign unused_ok = ^{req_addr[31:ADDR_W+2], window[2*DATA_W-1:DATA_W]};
endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit. The stimulus process issues requests. A
// byte-addressed reference memory (64 KiB, matching the 2^14-word SRAM)
// yields the expected SRAM beats and responses, and these are queued. A
// negedge monitor pops and compares whenever the DUT drives an SRAM beat or a
// response. A behavioural SRAM model sits on the DUT's SRAM port.
module tb_dmem_access_unit;
    localparam int ADDR_W = 14;
    localparam int NWORDS = 1 << ADDR_W;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_rsp_t;

    typedef struct {
        logic [13:0] a;
        logic [3:0]  web;
        logic [31:0] di;
        logic        oe;
        logic        chk_di;
    } exp_beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sram_cs;
    logic        sram_oe;
    logic [3:0]  sram_web;
    logic [13:0] sram_a;
    logic [31:0] sram_di;
    logic [31:0] sram_do = '0;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .sram_cs    (sram_cs),
        .sram_oe    (sram_oe),
        .sram_web   (sram_web),
        .sram_a     (sram_a),
        .sram_di    (sram_di),
        .sram_do    (sram_do)
    );

    // SRAM: samples at the clock edge when cs is high; read data follows one cycle later.
    logic [31:0] mem [NWORDS];
    always @(posedge clk) begin
        if (sram_cs) begin
            sram_do <= mem[sram_a];
            for (int i = 0; i < 4; i++)
                if (!sram_web[i]) mem[sram_a][8*i +: 8] <= sram_di[8*i +: 8];
        end
    end

    logic [7:0]  ref_mem [65536];
    exp_rsp_t    rsp_q[$];
    exp_beat_t   beat_q[$];
    int          cyc = 0;
    logic        rst_q = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [2:0]  ld_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin : monitor
        exp_beat_t b;
        exp_rsp_t  r;
        if (rst_q) begin
            chk("rst_cs",        32'(sram_cs),   32'h0);
            chk("rst_oe",        32'(sram_oe),   32'h0);
            chk("rst_web",       32'(sram_web),  32'hF);
            chk("rst_a",         32'(sram_a),    32'h0);
            chk("rst_di",        sram_di,        32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_rdata",     rsp_rdata,      32'h0);
            chk("rst_err",       32'(rsp_err),   32'h0);
            chk("rst_ready",     32'(req_ready), 32'(!rst));
        end else begin
            if (sram_cs) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat_cs", 32'(sram_cs), 32'h0);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_addr", 32'(sram_a),   32'(b.a));
                    chk("beat_web",  32'(sram_web), 32'(b.web));
                    chk("beat_oe",   32'(sram_oe),  32'(b.oe));
                    if (b.chk_di) chk("beat_di", sram_di, b.di);
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_cycle",     32'(cyc), 32'(r.cyc));
                    chk("rsp_err",       32'(rsp_err), 32'(r.err));
                    chk("rsp_rdata",     rsp_rdata, r.rdata);
                    chk("rsp_oe",        32'(sram_oe), 32'h1);
                    chk("beats_missing", 32'(beat_q.size()), 32'h0);
                end
            end
        end
    end

    // Issue one request and queue what it must produce. abort=1 pulls rst
    // during the second cycle after acceptance (S2 of a split access). The
    // SRAM still samples that second beat, so both beats count as written.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit abort);
        exp_rsp_t    r;
        exp_beat_t   b;
        int          n, sz, nbeats, lat, off;
        bit          ill;
        logic [31:0] v;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, expected 1", req_ready, n);
            $fatal(1, "request never accepted");
        end
        off    = int'(addr[1:0]);
        sz     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ill    = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        nbeats = ill ? 0 : ((off + sz > 4) ? 2 : 1);
        for (int bi = 0; bi < nbeats; bi++) begin
            b.a      = 14'(int'(addr[15:2]) + bi);
            b.web    = 4'hF;
            b.oe     = (bi == 1);
            b.chk_di = we;
            for (int k = 0; k < sz; k++)
                if (we && (off + k) / 4 == bi) b.web[2'((off + k) % 4)] = 1'b0;
            b.di = (bi == 0) ? (wd << (8 * off)) : (wd >> (8 * (4 - off)));
            beat_q.push_back(b);
        end
        lat = ill ? 1 : ((nbeats == 2) ? 3 : 2);
        v = 32'h0;
        if (!ill && !we) begin
            for (int k = 0; k < sz; k++)
                v = v | (32'(ref_mem[16'(int'(addr[15:0]) + k)]) << (8 * k));
            case (f3)
                3'd0:    v = {{24{v[7]}}, v[7:0]};
                3'd1:    v = {{16{v[15]}}, v[15:0]};
                default: ;
            endcase
        end
        r.cyc   = cyc + lat;
        r.rdata = v;
        r.err   = ill;
        if (!abort) rsp_q.push_back(r);
        if (we && !ill)
            for (int k = 0; k < sz; k++)
                ref_mem[16'(int'(addr[15:0]) + k)] = 8'(wd >> (8 * k));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (abort) begin
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            @(posedge clk);
            #1 rst = 1'b0;
        end
    endtask

    initial begin : stim
        logic [31:0] v;
        logic        we_r;
        logic [2:0]  f3_r;
        logic [31:0] a_r;
        int          n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < NWORDS; i++) begin
            v = $urandom;
            mem[14'(i)] <= v;
            for (int l = 0; l < 4; l++) ref_mem[16'(4 * i + l)] = 8'(v >> (8 * l));
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0); // aligned SW
        issue(1'b1, 3'b010, 32'h0000_0010, 32'h80FF_1234, 1'b0);
        issue(1'b1, 3'b010, 32'h0000_0014, 32'h5566_AABB, 1'b0);
        issue(1'b0, 3'b000, 32'h0000_0013, 32'h0, 1'b0);         // LB  -> FFFFFF80
        issue(1'b0, 3'b100, 32'h0000_0013, 32'h0, 1'b0);         // LBU -> 00000080
        issue(1'b0, 3'b001, 32'h0000_0012, 32'h0, 1'b0);         // LH  -> FFFF80FF
        issue(1'b0, 3'b010, 32'h0000_0012, 32'h0, 1'b0);         // split LW -> AABB80FF
        issue(1'b1, 3'b001, 32'h0000_0007, 32'h0000_CAFE, 1'b0); // split SH
        issue(1'b0, 3'b101, 32'h0000_0007, 32'h0, 1'b0);         // LHU -> 0000CAFE
        issue(1'b0, 3'b010, 32'h0000_FFFE, 32'h0, 1'b0);         // wrap 16383 -> 0
        issue(1'b1, 3'b010, 32'h0001_FFFD, 32'hA1B2_C3D4, 1'b0); // wrapping split SW
        issue(1'b0, 3'b010, 32'h0000_FFFD, 32'h0, 1'b0);
        issue(1'b0, 3'b011, 32'h0000_0040, 32'h0, 1'b0);         // illegal load
        issue(1'b0, 3'b111, 32'h0000_0041, 32'h0, 1'b0);
        issue(1'b1, 3'b101, 32'h0000_0044, 32'h1234_5678, 1'b0); // illegal store
        issue(1'b1, 3'b010, 32'h0000_0021, 32'h1122_3344, 1'b1); // split SW, reset in S2
        issue(1'b0, 3'b010, 32'h0000_0021, 32'h0, 1'b0);

        for (int t = 0; t < 400; t++) begin
            we_r = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a_r = $urandom;
                1, 2:    a_r = 32'($urandom_range(0, 63));
                default: a_r = 32'h0000_FFC0 + 32'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 4) == 0) f3_r = 3'($urandom_range(0, 7));
            else if (we_r)                 f3_r = 3'($urandom_range(0, 2));
            else                           f3_r = ld_tab[$urandom_range(0, 4)];
            issue(we_r, f3_r, a_r, $urandom, 1'b0);
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end

        n = 0;
        while (rsp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0) begin
            $display("FAIL rsp_drain: %0d responses outstanding, expected 0", rsp_q.size());
            $fatal(1, "responses missing");
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
